// File: rtl/fetch_unit_pkg.sv
// Shared RV32I fetch definitions: opcodes, type_decode bit indices, funct3 values,
// the FIFO entry layout and the opcode-to-type decoder.
package fetch_unit_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam int unsigned TYPE_W      = 9;
  localparam int unsigned TYPE_OP     = 8;
  localparam int unsigned TYPE_OP_IMM = 7;
  localparam int unsigned TYPE_LOAD   = 6;
  localparam int unsigned TYPE_STORE  = 5;
  localparam int unsigned TYPE_BRANCH = 4;
  localparam int unsigned TYPE_JAL    = 3;
  localparam int unsigned TYPE_JALR   = 2;
  localparam int unsigned TYPE_AUIPC  = 1;
  localparam int unsigned TYPE_LUI    = 0;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [TYPE_W-1:0] decode_type(input logic [6:0] opc);
    logic [TYPE_W-1:0] t;
    t = '0;
    case (opc)
      OPC_OP:     t[TYPE_OP]     = 1'b1;
      OPC_OP_IMM: t[TYPE_OP_IMM] = 1'b1;
      OPC_LOAD:   t[TYPE_LOAD]   = 1'b1;
      OPC_STORE:  t[TYPE_STORE]  = 1'b1;
      OPC_BRANCH: t[TYPE_BRANCH] = 1'b1;
      OPC_JAL:    t[TYPE_JAL]    = 1'b1;
      OPC_JALR:   t[TYPE_JALR]   = 1'b1;
      OPC_AUIPC:  t[TYPE_AUIPC]  = 1'b1;
      OPC_LUI:    t[TYPE_LUI]    = 1'b1;
      default:    t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order synchronous FIFO of {pc, instr} entries with push, pop and flush.
// On a same-cycle pop and flush the popped head is consumed and the FIFO then empties.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign do_push = push_i & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC ownership, credit-limited imem requests, redirect
// flush with response discard, and combinational decode of the buffered head.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [8:0]  type_decode_o,
  output logic [2:0]  function_3_o,
  output logic        function_7_o,
  output logic        illegal_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_fetch_q, pc_fetch_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          gnt;
  logic          drop_rsp;
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;
  logic [31:0]   pc_next;
  logic [CW-1:0] occ_next;
  logic          credit;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_in;
  logic [8:0]    head_type;

  assign gnt      = req_q & imem_gnt_i;
  assign drop_rsp = imem_rvalid_i & (discard_q != '0);
  assign push     = imem_rvalid_i & (discard_q == '0) & ~redirect_i;
  assign pop      = instr_valid_o & instr_ready_i;
  assign redir_pc = redirect_pc_i & ~32'h3;
  assign fifo_in  = '{pc: resp_pc_q, instr: imem_rdata_i};

  // Counters, response PC tracking and request issue under the credit rule.
  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt) - CW'(imem_rvalid_i);
    discard_d     = discard_q - CW'(drop_rsp) + CW'(gnt & stale_q);
    resp_pc_d     = push ? resp_pc_q + 32'd4 : resp_pc_q;
    occ_next      = fifo_count + CW'(push) - CW'(pop);
    pc_next       = pc_fetch_q;
    req_d         = 1'b0;
    addr_d        = addr_q;
    pc_fetch_d    = pc_fetch_q;
    stale_d       = 1'b0;

    if (redirect_i) begin
      // Every grant not yet returned after this edge predates the redirect.
      discard_d = outstanding_d;
      resp_pc_d = redir_pc;
      occ_next  = '0;
      pc_next   = redir_pc;
    end

    credit = ((CW+1)'(occ_next) + (CW+1)'(outstanding_d)) < (CW+1)'(FIFO_DEPTH);

    if (req_q && !imem_gnt_i) begin
      req_d      = 1'b1;
      pc_fetch_d = pc_next;
      stale_d    = stale_q | redirect_i;
    end else if (credit) begin
      req_d      = 1'b1;
      addr_d     = pc_next;
      pc_fetch_d = pc_next + 32'd4;
    end else begin
      pc_fetch_d = pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
      pc_fetch_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      req_q         <= req_d;
      addr_q        <= addr_d;
      pc_fetch_q    <= pc_fetch_d;
      resp_pc_q     <= resp_pc_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (fifo_in),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign head_type     = decode_type(fifo_head.instr[6:0]);
  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = fifo_head.instr;
  assign pc_o          = fifo_head.pc;
  assign type_decode_o = instr_valid_o ? head_type : '0;
  assign function_3_o  = instr_valid_o ? fifo_head.instr[14:12] : 3'b000;
  assign function_7_o  = instr_valid_o & fifo_head.instr[30];
  assign illegal_o     = instr_valid_o & (head_type == '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with configurable latency and grant
// gating, a redirect-epoch model of which responses survive, and in-order head checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [8:0]  type_decode_o;
  logic [2:0]  function_3_o;
  logic        function_7_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .type_decode_o (type_decode_o),
    .function_3_o  (function_3_o),
    .function_7_o  (function_7_o),
    .illegal_o     (illegal_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          tag;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  rsp_t        rsp_q[$];
  exp_t        exp_q[$];
  rsp_t        cur;
  exp_t        e;
  bit          cur_v;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          req_tag = 0;
  int          lat = 1;
  int          pops = 0;
  int          first_gnt = -1;
  int          first_valid = -1;
  logic [31:0] first_gnt_addr = '0;
  bit          gnt_en = 1'b0;
  bit          pending = 1'b0;
  logic [31:0] held_addr = '0;
  bit          watch_new = 1'b0;
  logic [31:0] watch_new_addr = '0;
  bit          watch_gnt = 1'b0;
  logic [31:0] watch_gnt_addr = '0;
  bit          combo_chk = 1'b0;
  logic [31:0] stall_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] tb_type(input logic [31:0] w);
    case (w[6:0])
      7'h33:   return 9'b1_0000_0000;
      7'h13:   return 9'b0_1000_0000;
      7'h03:   return 9'b0_0100_0000;
      7'h23:   return 9'b0_0010_0000;
      7'h63:   return 9'b0_0001_0000;
      7'h6F:   return 9'b0_0000_1000;
      7'h67:   return 9'b0_0000_0100;
      7'h17:   return 9'b0_0000_0010;
      7'h37:   return 9'b0_0000_0001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [6:0] opc_for(input logic [3:0] k);
    case (k)
      4'd0: return 7'h33;  4'd1: return 7'h13;  4'd2: return 7'h03;  4'd3: return 7'h23;
      4'd4: return 7'h63;  4'd5: return 7'h6F;  4'd6: return 7'h67;  4'd7: return 7'h17;
      4'd8: return 7'h37;  4'd9: return 7'h7F;  4'd10: return 7'h13; 4'd11: return 7'h33;
      4'd12: return 7'h0F; 4'd13: return 7'h03; 4'd14: return 7'h33; default: return 7'h13;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h00A5_0533;
      32'h44:  return 32'h40A5_0533;
      32'h48:  return 32'hFFFF_FFFF;
      default: return {a[10:2] ^ 9'h1A5, a[17:2], opc_for(a[5:2])};
    endcase
  endfunction

  // One clock: drive memory response/grant, check mid-cycle, update the model.
  task automatic cycle();
    if (imem_req_o) begin
      if (pending) begin
        check("req_hold_addr", imem_addr_o, held_addr);
      end else begin
        req_tag = epoch;
        if (watch_new) begin
          check("new_req_addr", imem_addr_o, watch_new_addr);
          watch_new = 1'b0;
        end
      end
    end else if (pending) begin
      check("req_hold", 32'(imem_req_o), 32'd1);
    end
    imem_gnt_i = gnt_en & imem_req_o;
    cur_v = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    if (cur_v) cur = rsp_q.pop_front();
    imem_rvalid_i = cur_v;
    imem_rdata_i  = cur_v ? mem_word(cur.addr) : 32'h0;
    #4;
    check("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
    check("valid_vs_model", 32'(instr_valid_o), 32'(exp_q.size() != 0));
    if (combo_chk) begin
      check("combo_cycle", 32'({instr_valid_o, instr_ready_i, imem_gnt_i, imem_rvalid_i}), 32'hF);
      combo_chk = 1'b0;
    end
    if (instr_valid_o && first_valid < 0) first_valid = cyc;
    if (instr_valid_o && instr_ready_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("head_pc", pc_o, e.pc);
      check("head_instr", instr_o, e.instr);
      check("head_type", 32'(type_decode_o), 32'(tb_type(e.instr)));
      check("head_illegal", 32'(illegal_o), 32'(tb_type(e.instr) == 9'b0));
      check("head_f3", 32'(function_3_o), 32'(e.instr[14:12]));
      check("head_f7", 32'(function_7_o), 32'(e.instr[30]));
      if (e.pc == 32'h40) begin
        check("add_type", 32'(type_decode_o), 32'h100);
        check("add_f3", 32'(function_3_o), 32'd0);
        check("add_f7", 32'(function_7_o), 32'd0);
      end
      if (e.pc == 32'h44) check("sub_f7", 32'(function_7_o), 32'd1);
      if (e.pc == 32'h48) check("ones_illegal", 32'(illegal_o), 32'd1);
      pops++;
    end
    if (redirect_i) exp_q.delete();
    if (cur_v && cur.tag == epoch && !redirect_i)
      exp_q.push_back('{pc: cur.addr, instr: mem_word(cur.addr)});
    if (redirect_i) begin
      epoch++;
      watch_new      = 1'b1;
      watch_new_addr = redirect_pc_i & ~32'h3;
    end
    if (imem_gnt_i) begin
      rsp_q.push_back('{addr: imem_addr_o, tag: req_tag, due: cyc + lat});
      if (first_gnt < 0) begin
        first_gnt      = cyc;
        first_gnt_addr = imem_addr_o;
      end
      if (watch_gnt) begin
        check("stale_gnt_addr", imem_addr_o, watch_gnt_addr);
        watch_gnt = 1'b0;
      end
    end
    pending   = imem_req_o & ~imem_gnt_i;
    held_addr = imem_addr_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    cycle();
    redirect_i    = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_type", 32'(type_decode_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_f3f7", 32'({function_3_o, function_7_o}), 32'd0);

    // Sequential fetch, 1-cycle memory, consumer always ready.
    lat = 1; gnt_en = 1'b1; instr_ready_i = 1'b1;
    run(24);
    check("first_gnt_addr", first_gnt_addr, 32'h0);
    check("first_valid_latency", 32'(first_valid - first_gnt), 32'd2);
    pops = 0;
    run(16);
    check("throughput", 32'(pops), 32'd16);

    // Stalled consumer: FIFO fills, requests stop, then drain in order.
    instr_ready_i = 1'b0;
    run(10);
    check("full_req_drop", 32'(imem_req_o), 32'd0);
    check("full_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    run(8);

    // Redirect with several responses in flight.
    lat = 3;
    run(6);
    redirect_to(32'h0000_0102);
    run(14);
    check("redir_new_req_seen", 32'(watch_new), 32'd0);

    // Grant withheld; redirect while a request is pending.
    lat = 1;
    run(4);
    gnt_en = 1'b0;
    run(2);
    check("pending_req", 32'(imem_req_o), 32'd1);
    stall_addr = imem_addr_o;
    run(1);
    redirect_to(32'h0000_0300);
    run(1);
    watch_gnt      = 1'b1;
    watch_gnt_addr = stall_addr;
    gnt_en         = 1'b1;
    run(12);
    check("stale_gnt_seen", 32'(watch_gnt), 32'd0);
    check("post_stall_req_seen", 32'(watch_new), 32'd0);

    // Redirect coinciding with gnt, rvalid and pop.
    run(8);
    combo_chk = 1'b1;
    redirect_to(32'h0000_0500);
    run(12);
    check("combo_new_req_seen", 32'(watch_new), 32'd0);

    run(6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core. It owns the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small in-order FIFO. Each buffered instruction is presented to the control unit with its PC, funct3, funct7[5] and the 9-bit one-hot type code, under a valid/ready handshake. Branch/jump redirects flush all in-flight and buffered fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word address of request, bits [1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in grant order, ≥1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  taken branch/jump, flush and refetch
- redirect_pc_i  in  32  new PC; bits [1:0] ignored (forced 0)
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  consumer accepts head
- instr_o  out  32  head instruction
- pc_o  out  32  head PC
- type_decode_o  out  9  one-hot type to control unit
- function_3_o  out  3  instr[14:12]
- function_7_o  out  1  instr[30]
- illegal_o  out  1  head opcode not one of the nine supported

## Operation
- type_decode_o bit mapping:
  - 8 = OP 0110011
  - 7 = OP-IMM 0010011
  - 6 = LOAD 0000011
  - 5 = STORE 0100011
  - 4 = BRANCH 1100011
  - 3 = JAL 1101111
  - 2 = JALR 1100111
  - 1 = AUIPC 0010111
  - 0 = LUI 0110111
- Decode of the head entry is combinational. Unknown opcode → type_decode_o=0, illegal_o=1. All decode outputs are 0 when instr_valid_o=0.
- Counters (all registered):
  - occ = FIFO occupancy
  - outstanding = granted, unreturned requests
  - discard = outstanding responses to drop
- Issue condition: occ + outstanding < FIFO_DEPTH, and not in the reset cycle.
- Once imem_req_o is raised, it and imem_addr_o hold stable until imem_gnt_i, even across a redirect.
- On gnt, pc_fetch advances by 4, mod 2^32.
- rvalid with discard>0: word dropped, discard decrements. Otherwise the word is pushed with its PC. The PC comes from a parallel PC queue, or from the head PC + 4·position.
- Pop on instr_valid_o & instr_ready_i.
- Redirect:
  - FIFO cleared.
  - discard ← outstanding + gnt_this_cycle − (rvalid_this_cycle & discard==0 ? 1 : 0) adjusted so that every un-returned pre-redirect grant is dropped. An rvalid in the redirect cycle is itself dropped.
  - pc_fetch ← redirect_pc_i & ~3.
  - A pending un-granted request still completes at its old address; its grant adds to discard.
- Simultaneous redirect and pop: the pop completes, then the flush takes effect.
- Simultaneous redirect and gnt on an old request: that response is discarded.
- PC wrap 32'hFFFF_FFFC → 0 is silent.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, all decode outputs 0, occ=outstanding=discard=0.
- First imem_req_o is in the first cycle after rst deasserts.
- Latency: gnt in cycle N, rvalid in N+1, instr_valid_o in N+2.
- Sustained one instruction per cycle with 1-cycle memory and FIFO_DEPTH≥3 while instr_ready_i=1.
- After a redirect in cycle R, the earliest request to the new PC is in R+1.
- Full FIFO with instr_ready_i=0: no new requests. Outstanding responses always fit, by the credit rule.
- rst mid-operation: all state returns to reset values next edge. Late responses from pre-reset grants are not tracked; memory must be reset together with this block.

## Structure
- RV32_pkg.vh holds:
  - opcode constants (OPC_OP … OPC_LUI)
  - TYPE_* bit-index constants for type_decode
  - FUNCT3_* constants, already present there
- Sub-module fetch_fifo holds the parameterised sync FIFO:
  - {pc, instr} entries
  - push/pop/flush
  - count output
- Decode and issue/credit logic stay in fetch_unit.

## Test plan
- Reset release, gnt always 1, rvalid one cycle later, ready=1 → addresses 0,4,8,…; first instr_valid_o two cycles after first gnt; one instruction per cycle.
- Head = 32'h00A50533 (add) → type_decode_o=9'b1_0000_0000, function_3_o=0, function_7_o=0. Head = 32'h40A50533 → function_7_o=1. Head = 32'hFFFFFFFF → illegal_o=1.
- ready=0 for 10 cycles → occ saturates at 4, imem_req_o drops, no overflow. Ready=1 again → 4 entries drain in order.
- Redirect to 32'h0000_0102 with 2 outstanding → both responses dropped, next address 32'h0000_0100, next valid head pc_o=32'h100.
- imem_gnt_i=0 for 5 cycles → imem_addr_o unchanged. A redirect during that window → old address still granted, its response discarded.
- Redirect, gnt, rvalid and pop in the same cycle → the popped head is the last old instruction delivered, with no stale entries after it.
